tdm_demux81: RTL and testbench

- Time-division demultiplexer: the receive end of an 8:1 serial selector path.
- Takes a 1-bit TDM stream, one slot per valid beat, with a frame-sync marker on slot 0.
- Each slot bit is steered into its own channel register; the assembled 8-bit frame is published in parallel.
- Sits after the serial link and before per-channel logic.

---
 rtl/tdm_pkg.sv | 23 ++
 rtl/tdm_demux81_slot_dec.sv | 19 +
 rtl/tdm_demux81.sv | 126 ++++++++++++
 tb/tb_tdm_demux81.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types and constants for tdm_demux81 (optional feature macro: TDM_PARITY_EN)
package tdm_pkg;

  typedef enum logic {HUNT, RECV} state_t;

  localparam int NCH_DEF = 8;
`ifdef TDM_PARITY_EN
  // The slot counter also has to reach the parity slot, whose index is NCH.
  localparam int SLOT_W_DEF = 4;
`else
  localparam int SLOT_W_DEF = 3;
`endif

  // Number of beats in one frame, including the parity slot when it is built in.
  function automatic int frame_len(input int nch);
`ifdef TDM_PARITY_EN
    return nch + 1;
`else
    return nch;
`endif
  endfunction

endpackage

// File: rtl/tdm_demux81_slot_dec.sv
// rtl/tdm_demux81_slot_dec.sv - slot index to one-hot shadow write-enable decoder
module slot_dec #(
  parameter int NCH    = 8,
  parameter int SLOT_W = 3
) (
  input  logic [SLOT_W-1:0] idx,
  input  logic              en,
  output logic [NCH-1:0]    we
);

  // One enable per channel; an index past the last channel (parity slot) enables nothing.
  always_comb begin
    we = '0;
    for (int i = 0; i < NCH; i++) begin
      we[i] = en && (idx == SLOT_W'(i));
    end
  end

endmodule

// File: rtl/tdm_demux81.sv
// rtl/tdm_demux81.sv - 8:1 TDM receive demultiplexer (optional feature macro: TDM_PARITY_EN)
module tdm_demux81
  import tdm_pkg::*;
#(
  parameter int NCH    = NCH_DEF,
  parameter int SLOT_W = SLOT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [NCH-1:0]    dout,
  output logic              dout_valid,
  output logic [SLOT_W-1:0] slot,
  output logic              locked,
  output logic              sync_err
`ifdef TDM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int              FRAME_LEN = frame_len(NCH);
  localparam logic [SLOT_W-1:0] LAST    = SLOT_W'(FRAME_LEN - 1);

  state_t              state, state_n;
  logic [SLOT_W-1:0]   slot_q, slot_n;
  logic [NCH-1:0]      shadow, shadow_d, we;
  logic [SLOT_W-1:0]   cap_idx;
  logic                cap_en;
  logic                publish;
  logic                se_n;
`ifdef TDM_PARITY_EN
  logic                pe_n;
`endif

  slot_dec #(.NCH(NCH), .SLOT_W(SLOT_W)) u_slot_dec (
    .idx (cap_idx),
    .en  (cap_en),
    .we  (we)
  );

  // Shadow with this beat's bit merged in; also the frame published on completion,
  // so the last data bit reaches dout on the same edge it is sampled.
  assign shadow_d = (shadow & ~we) | ({NCH{din}} & we);

  // Framing decisions for the current beat: capture, slot advance, publish, errors.
  always_comb begin
    state_n = state;
    slot_n  = slot_q;
    cap_en  = 1'b0;
    cap_idx = slot_q;
    publish = 1'b0;
    se_n    = 1'b0;
`ifdef TDM_PARITY_EN
    pe_n    = 1'b0;
`endif
    if (din_valid) begin
      case (state)
        HUNT: begin
          if (frame_sync) begin
            cap_en  = 1'b1;
            cap_idx = '0;
            slot_n  = SLOT_W'(1);
            state_n = RECV;
          end
        end
        RECV: begin
          if (frame_sync) begin
            // Sync anywhere but slot 0 means we lost alignment; restart the frame here.
            se_n    = (slot_q != '0);
            cap_en  = 1'b1;
            cap_idx = '0;
            slot_n  = SLOT_W'(1);
          end else if (slot_q == '0) begin
            se_n    = 1'b1;
            state_n = HUNT;
          end else if (slot_q == LAST) begin
            slot_n = '0;
`ifdef TDM_PARITY_EN
            if (din == ^shadow) publish = 1'b1;
            else                pe_n    = 1'b1;
`else
            cap_en  = 1'b1;
            publish = 1'b1;
`endif
          end else begin
            cap_en = 1'b1;
            slot_n = slot_q + SLOT_W'(1);
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  // State, slot counter, shadow capture, frame publish and one-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      slot_q     <= '0;
      shadow     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sync_err   <= 1'b0;
`ifdef TDM_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      slot_q     <= slot_n;
      shadow     <= shadow_d;
      dout_valid <= publish;
      sync_err   <= se_n;
      if (publish) dout <= shadow_d;
`ifdef TDM_PARITY_EN
      parity_err <= pe_n;
`endif
    end
  end

  assign slot   = slot_q;
  assign locked = (state == RECV);

endmodule

// File: tb/tb_tdm_demux81.sv
// tb/tb_tdm_demux81.sv - self-checking bench for tdm_demux81 (optional feature macro: TDM_PARITY_EN)
module tb_tdm_demux81;

  localparam int NCH = 8;
`ifdef TDM_PARITY_EN
  localparam int FL = NCH + 1;
  localparam int SW = 4;
`else
  localparam int FL = NCH;
  localparam int SW = 3;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           din, din_valid, frame_sync;
  logic [NCH-1:0] dout;
  logic           dout_valid;
  logic [SW-1:0]  slot;
  logic           locked, sync_err;
`ifdef TDM_PARITY_EN
  logic           parity_err;
`endif

  always #5 clk = ~clk;

  tdm_demux81 #(.NCH(NCH), .SLOT_W(SW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .slot       (slot),
    .locked     (locked),
    .sync_err   (sync_err)
`ifdef TDM_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a frame is just the queue of bits received since the last sync.
  bit             m_locked;
  bit             m_frame[$];
  logic [NCH-1:0] e_dout;
  bit             e_dv, e_se, e_pe;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_slot();
    return m_locked ? m_frame.size() : 0;
  endfunction

  task automatic check_all(input string ctx);
    check({ctx, ".dout"},       32'(dout),       32'(e_dout));
    check({ctx, ".dout_valid"}, 32'(dout_valid), 32'(e_dv));
    check({ctx, ".slot"},       32'(slot),       32'(exp_slot()));
    check({ctx, ".locked"},     32'(locked),     32'(m_locked));
    check({ctx, ".sync_err"},   32'(sync_err),   32'(e_se));
`ifdef TDM_PARITY_EN
    check({ctx, ".parity_err"}, 32'(parity_err), 32'(e_pe));
`endif
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_frame.delete();
    e_dout = '0;
    e_dv = 0; e_se = 0; e_pe = 0;
  endtask

  task automatic model(input bit v, input bit d, input bit fs);
    logic [NCH-1:0] w;
    e_dv = 0; e_se = 0; e_pe = 0;
    if (!v) return;
    if (!m_locked) begin
      if (fs) begin
        m_frame.delete();
        m_frame.push_back(d);
        m_locked = 1;
      end
    end else if (fs) begin
      if (m_frame.size() != 0) e_se = 1;
      m_frame.delete();
      m_frame.push_back(d);
    end else if (m_frame.size() == 0) begin
      e_se = 1;
      m_locked = 0;
    end else begin
      m_frame.push_back(d);
      if (m_frame.size() == FL) begin
        for (int i = 0; i < NCH; i++) w[i] = m_frame[i];
`ifdef TDM_PARITY_EN
        if (m_frame[NCH] == ^w) begin e_dout = w; e_dv = 1; end
        else e_pe = 1;
`else
        e_dout = w;
        e_dv = 1;
`endif
        m_frame.delete();
      end
    end
  endtask

  task automatic step(input bit v, input bit d, input bit fs, input string ctx);
    din_valid  = v;
    din        = d;
    frame_sync = fs;
    @(posedge clk);
    model(v, d, fs);
    #1;
    check_all(ctx);
  endtask

  task automatic send_bits(input logic [NCH-1:0] val, input bit gaps, input string ctx);
    for (int s = 0; s < NCH; s++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom), 1'($urandom), ctx);
      step(1'b1, val[s], s == 0, ctx);
    end
  endtask

  task automatic send_frame(input logic [NCH-1:0] val, input bit gaps, input string ctx);
    send_bits(val, gaps, ctx);
`ifdef TDM_PARITY_EN
    step(1'b1, ^val, 1'b0, ctx);
`endif
  endtask

  initial begin
    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, "idle");

    // Single frame, dout_valid exactly one cycle after the last beat.
    send_frame(8'hA5, 1'b0, "a5");
    check("a5.const_dout", 32'(dout), 32'h0A5);
    check("a5.const_locked", 32'(locked), 32'h1);
    step(1'b0, 1'b0, 1'b0, "a5_after");
    check("a5.pulse_width", 32'(dout_valid), 32'h0);

    // Back-to-back frames with random gaps.
    send_frame(8'h3C, 1'b1, "b2b0");
    check("b2b.first", 32'(dout), 32'h03C);
    send_frame(8'hC3, 1'b1, "b2b1");
    check("b2b.second", 32'(dout), 32'h0C3);

    // Early sync at slot 4, then a fresh frame completes.
    for (int s = 0; s < 4; s++) step(1'b1, 1'b1, s == 0, "esync_pre");
    step(1'b1, 1'b0, 1'b1, "esync");
    check("esync.slot", 32'(slot), 32'h1);
    check("esync.err", 32'(sync_err), 32'h1);
    for (int s = 1; s < FL; s++) step(1'b1, 1'(s == 1), 1'b0, "esync_post");

    // Missing sync on slot 0 drops lock; unsynced beats are ignored.
    send_frame(8'h96, 1'b0, "pre_miss");
    step(1'b1, 1'b1, 1'b0, "miss");
    check("miss.locked", 32'(locked), 32'h0);
    repeat (5) step(1'b1, 1'($urandom), 1'b0, "hunt");
    send_frame(8'h5A, 1'b0, "relock");

    // Asynchronous reset at slot 5.
    for (int s = 0; s < 5; s++) step(1'b1, 1'b1, s == 0, "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_frame(8'h71, 1'b0, "post_rst");

`ifdef TDM_PARITY_EN
    send_frame(8'h0F, 1'b0, "par_ok");
    check("par_ok.dout", 32'(dout), 32'h00F);
    send_frame(8'h33, 1'b0, "par_prev");
    send_bits(8'h0F, 1'b0, "par_bad");
    step(1'b1, 1'b1, 1'b0, "par_bad_beat");
    check("par_bad.hold", 32'(dout), 32'h033);
    check("par_bad.err", 32'(parity_err), 32'h1);
`endif

    // Randomised traffic: frames with gaps, then unconstrained beats.
    repeat (20) send_frame(NCH'($urandom), 1'b1, "rand_frame");
    repeat (300) step(1'($urandom_range(0, 3) != 0), 1'($urandom),
                      1'($urandom_range(0, 9) == 0), "rand_beat");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
